// File: rtl/muladd_pkg.sv
// Shared definitions for the MULADD sequencer.
//   muladd_state_t : sequencer FSM state encoding (2 bits)
//   FUNCT_MULADD   : R-type funct field that selects MULADD
//   ALUCTL_MULADD  : ALU control code the decoder emits for MULADD
package muladd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } muladd_state_t;

    localparam logic [5:0] FUNCT_MULADD  = 6'b011001;
    localparam logic [2:0] ALUCTL_MULADD = 3'b011;

endpackage

// File: rtl/muladd_seq_dp.sv
// Datapath for the MULADD sequencer: operand, accumulator and count registers,
// the shift-add engine and the final adder.
// Ports:
//   clk, reset        clock, async active-low reset
//   load              capture srca/srcb/srcc, clear acc and count
//   step              one shift-add multiply iteration
//   finish            {carry, result} <= acc + addend
//   srca/srcb/srcc    multiplicand, multiplier, addend
//   last_step         current MUL iteration is the final one
//   result, carry     held outputs of the final addition
module muladd_seq_dp
    import muladd_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0] srcc,
    output logic             last_step,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mplier_next;

    assign mplier_next = mplier >> 1;

    // Early exit looks at the multiplier after this cycle's shift, so at least
    // one MUL iteration always runs.
    assign last_step = (count == CW'(WIDTH - 1)) ||
                       ((EARLY_TERM != 0) && (mplier_next == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand  <= '0;
            mplier <= '0;
            addend <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= srca;
            mplier <= srcb;
            addend <= srcc;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier_next;
            count  <= count + 1'b1;
        end
    end

    // result/carry only move on a committed ADD; flush and IDLE leave them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
            carry  <= 1'b0;
        end else if (finish) begin
            {carry, result} <= {1'b0, acc} + {1'b0, addend};
        end
    end

endmodule

// File: rtl/muladd_sequencer.sv
// Iterative MULADD sequencer: result = srca*srcb + srcc (low WIDTH bits) on a
// shift-add engine, holding the pipeline stall while it runs.
// Ports:
//   clk, reset        clock, async active-low reset
//   start             request a MULADD (sampled in IDLE only)
//   srca/srcb/srcc    multiplicand, multiplier, addend
//   flush             abort the operation in flight
//   stall             freeze fetch/decode/execute
//   busy              sequencer not in IDLE
//   done              one-cycle pulse, result valid
//   result, carry     final sum and its carry-out
//
// state | meaning
// IDLE  | waiting for start
// MUL   | one multiplier bit per cycle
// ADD   | add accumulator and addend into result/carry
// DONE  | done pulse, pipeline released
module muladd_sequencer
    import muladd_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int EARLY_TERM = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [WIDTH-1:0] srcc,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    muladd_state_t state;
    muladd_state_t state_next;
    logic          load;
    logic          step;
    logic          finish;
    logic          last_step;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        done       = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    load       = 1'b1;
                    // keep stall low while reset is held, even if start is high
                    stall      = reset;
                    state_next = MUL;
                end
            end
            MUL: begin
                step  = 1'b1;
                stall = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = ADD;
                end
            end
            ADD: begin
                stall = 1'b1;
                if (flush) begin
                    state_next = IDLE;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // already committed: flush here does not cancel the pulse
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    muladd_seq_dp #(
        .WIDTH      (WIDTH),
        .EARLY_TERM (EARLY_TERM)
    ) u_dp (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .srca      (srca),
        .srcb      (srcb),
        .srcc      (srcc),
        .last_step (last_step),
        .result    (result),
        .carry     (carry)
    );

endmodule

// File: tb/tb_muladd_sequencer.sv
// Bench for muladd_sequencer: one instance without and one with early
// termination, shared stimulus, timeline model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_muladd_sequencer;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [W-1:0] srca  = '0;
    logic [W-1:0] srcb  = '0;
    logic [W-1:0] srcc  = '0;

    logic         stall  [2];
    logic         busy   [2];
    logic         done   [2];
    logic         carry  [2];
    logic [W-1:0] result [2];

    muladd_sequencer #(.WIDTH(W), .EARLY_TERM(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .srca(srca), .srcb(srcb),
        .srcc(srcc), .flush(flush), .stall(stall[0]), .busy(busy[0]),
        .done(done[0]), .result(result[0]), .carry(carry[0])
    );

    muladd_sequencer #(.WIDTH(W), .EARLY_TERM(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .srca(srca), .srcb(srcb),
        .srcc(srcc), .flush(flush), .stall(stall[1]), .busy(busy[1]),
        .done(done[1]), .result(result[1]), .carry(carry[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Number of MUL cycles: full width, or the multiplier's bit length (min 1).
    function automatic int mul_cycles(input logic [W-1:0] b, input int et);
        int n;
        if (et == 0) return W;
        n = 0;
        for (int j = 0; j < W; j++) if (b[j]) n = j + 1;
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [W:0] muladd_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [W-1:0] c);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return {1'b0, p[W-1:0]} + {1'b0, c};
    endfunction

    // Model: an accepted op is at elapsed cycle k (1 = first cycle after start);
    // cycles 1..n multiply, n+1 adds, n+2 pulses done.
    bit           m_active [2];
    int           m_k      [2];
    int           m_n      [2];
    logic [W:0]   m_pend   [2];
    logic [W-1:0] m_res    [2];
    logic         m_carry  [2];
    logic         e_stall, e_busy, e_done;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_active[i] = 1'b0;
                m_res[i]    = '0;
                m_carry[i]  = 1'b0;
                e_stall = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            end else if (!m_active[i]) begin
                e_busy  = 1'b0;
                e_done  = 1'b0;
                e_stall = start && !flush;
            end else begin
                e_busy  = 1'b1;
                e_done  = (m_k[i] == m_n[i] + 2);
                e_stall = (m_k[i] <= m_n[i] + 1);
            end
            chk($sformatf("dut%0d stall", i), stall[i], e_stall);
            chk($sformatf("dut%0d busy", i), busy[i], e_busy);
            chk($sformatf("dut%0d done", i), done[i], e_done);
            chk($sformatf("dut%0d result", i), result[i], m_res[i]);
            chk($sformatf("dut%0d carry", i), carry[i], m_carry[i]);

            if (reset) begin
                if (m_active[i]) begin
                    if (flush) begin
                        m_active[i] = 1'b0;
                    end else if (m_k[i] == m_n[i] + 1) begin
                        {m_carry[i], m_res[i]} = m_pend[i];
                        m_k[i]++;
                    end else if (m_k[i] == m_n[i] + 2) begin
                        m_active[i] = 1'b0;
                    end else begin
                        m_k[i]++;
                    end
                end else if (start && !flush) begin
                    m_active[i] = 1'b1;
                    m_k[i]      = 1;
                    m_n[i]      = mul_cycles(srcb, i);
                    m_pend[i]   = muladd_ref(srca, srcb, srcc);
                end
            end
        end
    end

    int done_cnt  [2] = '{0, 0};
    int stall_cnt [2] = '{0, 0};
    int last_done [2] = '{-1000, -1000};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) begin
                done_cnt[i]++;
                last_done[i] = cyc;
            end
            if (stall[i] === 1'b1) stall_cnt[i]++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, output int t0);
        tick();
        start = 1'b1; srca = a; srcb = b; srcc = c;
        t0 = cyc;
        tick();
        start = 1'b0; srca = $urandom; srcb = $urandom; srcc = $urandom;
    endtask

    initial begin
        int t0, t1, d0, s0;

        @(negedge clk);
        chk("reset busy", busy[0], 1'b0);
        chk("reset result", result[0], 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();

        // basic: 3*5+7
        d0 = done_cnt[0]; s0 = stall_cnt[0];
        issue(3, 5, 7, t0);
        repeat (40) tick();
        chk("basic done cycle", last_done[0] - t0, 34);
        chk("basic done count", done_cnt[0] - d0, 1);
        chk("basic stall cycles", stall_cnt[0] - s0, 34);
        chk("basic result", result[0], 22);
        chk("basic carry", carry[0], 0);
        chk("basic et done cycle", last_done[1] - t0, 5);
        chk("basic et result", result[1], 22);

        // early termination: 9*3+1
        issue(9, 3, 1, t0);
        repeat (40) tick();
        chk("et done cycle", last_done[1] - t0, 4);
        chk("et result", result[1], 28);

        // wrap
        issue(32'hFFFF_FFFF, 2, 3, t0);
        repeat (40) tick();
        chk("wrap result", result[0], 32'h0000_0001);
        chk("wrap carry", carry[0], 1);

        // flush in cycle 10, restart afterwards
        d0 = done_cnt[0];
        issue(4, 6, 1, t0);
        while (cyc < t0 + 10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush busy", busy[0], 0);
        chk("flush stall", stall[0], 0);
        chk("flush result held", result[0], 32'h0000_0001);
        chk("flush carry held", carry[0], 1);
        issue(2, 7, 5, t1);
        repeat (40) tick();
        chk("flush done count", done_cnt[0] - d0, 1);
        chk("flush restart done cycle", last_done[0] - t1, 34);
        chk("flush restart result", result[0], 19);

        // start while busy is ignored
        d0 = done_cnt[0];
        issue(10, 20, 5, t0);
        while (cyc < t0 + 5) tick();
        start = 1'b1; srca = 1; srcb = 1; srcc = 1;
        tick();
        start = 1'b0;
        repeat (40) tick();
        chk("busy ign done count", done_cnt[0] - d0, 1);
        chk("busy ign done cycle", last_done[0] - t0, 34);
        chk("busy ign result", result[0], 205);

        // reset mid-operation
        d0 = done_cnt[0];
        issue(100, 100, 0, t0);
        while (cyc < t0 + 15) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst busy", busy[0], 0);
        chk("midrst stall", stall[0], 0);
        chk("midrst result", result[0], 0);
        tick();
        reset = 1'b1;
        issue(2, 2, 0, t1);
        repeat (40) tick();
        chk("midrst done count", done_cnt[0] - d0, 1);
        chk("midrst done cycle", last_done[0] - t1, 34);
        chk("midrst result after", result[0], 4);

        // randomized traffic, model checks every cycle
        repeat (3000) begin
            tick();
            reset = ($urandom_range(0, 499) != 0);
            start = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 39) == 0);
            srca  = $urandom;
            srcb  = $urandom >> $urandom_range(0, 31);
            srcc  = $urandom;
        end
        tick();
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
